// File: rtl/kp_window_sched.sv
// Streaming 3x3 window scheduler: builds stride-1 windows from a raster pixel
// stream with two line buffers and registers the pooled result onto a valid/ready stream.
module kp_window_sched #(
  parameter int DWIDTH = 8,
  parameter int MAX_W  = 64,
  parameter int MAX_H  = 64,
  parameter int CW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CW-1:0]         cfg_w,
  input  logic [CW-1:0]         cfg_h,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DWIDTH-1:0]     pix_data,
  output logic [9*DWIDTH-1:0]   win_data,
  output logic                  win_valid,
  input  logic [DWIDTH-1:0]     pool_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DWIDTH-1:0]     res_data,
  output logic                  res_last
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t             state;
  logic [CW-1:0]      w_q, h_q, row, col;
  logic [AW-1:0]      col_idx;
  logic [DWIDTH-1:0]  linebuf0 [MAX_W];
  logic [DWIDTH-1:0]  linebuf1 [MAX_W];
  logic [DWIDTH-1:0]  win_p1 [3][3];
  logic               win_last_p1;
  logic               s1_take, s2_take, accept;
  logic               last_col, last_row, win_complete, geom_ok;

  assign s2_take      = !res_valid || res_ready;
  assign s1_take      = !win_valid || s2_take;
  assign pix_ready    = (state == LOAD) && s1_take;
  assign accept       = pix_valid && pix_ready;
  assign col_idx      = col[AW-1:0];
  assign last_col     = (col == w_q - CW'(1));
  assign last_row     = (row == h_q - CW'(1));
  assign win_complete = (row >= CW'(2)) && (col >= CW'(2));
  assign geom_ok      = (cfg_w >= CW'(3)) && (int'(cfg_w) <= MAX_W) &&
                        (cfg_h >= CW'(3)) && (int'(cfg_h) <= MAX_H);

  always_comb begin
    win_data = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_data[(r*3+c)*DWIDTH +: DWIDTH] = win_p1[r][c];
  end

  // Line buffers hold rows y-1 (linebuf0) and y-2 (linebuf1); never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf0[col_idx] <= pix_data;
      linebuf1[col_idx] <= linebuf0[col_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      row     <= '0;
      col     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (geom_ok) begin
              w_q   <= cfg_w;
              h_q   <= cfg_h;
              row   <= '0;
              col   <= '0;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + CW'(1);
              if (last_row) state <= FLUSH;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        FLUSH: begin
          // The tagged result is the last one produced, so its handshake empties the pipe.
          if (res_valid && res_ready && res_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: window shift register and window-valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p1[r][c] <= '0;
      win_valid   <= 1'b0;
      win_last_p1 <= 1'b0;
    end else begin
      if (s1_take) begin
        win_valid   <= accept && win_complete;
        win_last_p1 <= accept && win_complete && last_row && last_col;
      end
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_p1[r][0] <= win_p1[r][1];
          win_p1[r][1] <= win_p1[r][2];
        end
        win_p1[0][2] <= linebuf1[col_idx];
        win_p1[1][2] <= linebuf0[col_idx];
        win_p1[2][2] <= pix_data;
      end
    end
  end

  // Stage 2: pooled result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else if (s2_take) begin
      res_valid <= win_valid;
      res_last  <= win_valid && win_last_p1;
      if (win_valid) res_data <= pool_in;
    end
  end

endmodule

// File: tb/tb_kp_window_sched.sv
// Scoreboard bench for kp_window_sched: a frame-level reference model queues
// expected pooled results, and an independent monitor checks every presented result.
module tb_kp_window_sched;
  localparam int DW = 8;
  localparam int MW = 64;
  localparam int MH = 64;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   cfg_w = '0;
  logic [CW-1:0]   cfg_h = '0;
  logic            busy, done, cfg_err;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [DW-1:0]   pix_data = '0;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic [DW-1:0]   pool_in;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [DW-1:0]   res_data;
  logic            res_last;

  int errors = 0;
  int checks = 0;
  int stub_mode = 0;
  int rdy_mode = 0;
  int done_cnt = 0;
  bit captured = 1'b0;
  logic [71:0] first_win = '0;

  typedef struct {logic [7:0] d; logic last;} exp_t;
  exp_t exp_q[$];
  logic [7:0] frame_pix [0:4095];

  kp_window_sched #(.DWIDTH(DW), .MAX_W(MW), .MAX_H(MH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_data(win_data), .win_valid(win_valid), .pool_in(pool_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] max9(input logic [71:0] v);
    logic [7:0] m;
    m = v[7:0];
    for (int i = 1; i < 9; i++) if (v[i*8 +: 8] > m) m = v[i*8 +: 8];
    return m;
  endfunction

  // Pooling stub: newest pixel, or max over the window to exercise every element.
  always_comb pool_in = (stub_mode != 0) ? max9(win_data) : win_data[71:64];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d, expected no result", res_data);
        end else begin
          chk("res_data", 72'(res_data), 72'(exp_q[0].d));
          chk("res_last", 72'(res_last), 72'(exp_q[0].last));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
      if (win_valid && !captured) begin
        captured  = 1'b1;
        first_win = win_data;
      end
    end
  end

  // Result back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ~res_ready;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) frame_pix[i] = 8'(i);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) frame_pix[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference model: one result per full 3x3 neighbourhood, in raster order.
  task automatic push_frame(input int w, input int h);
    exp_t e;
    for (int y = 2; y < h; y++)
      for (int x = 2; x < w; x++) begin
        if (stub_mode != 0) begin
          e.d = 8'd0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              if (frame_pix[(y-2+r)*w + x-2+c] > e.d) e.d = frame_pix[(y-2+r)*w + x-2+c];
        end else begin
          e.d = frame_pix[y*w + x];
        end
        e.last = (y == h-1) && (x == w-1);
        exp_q.push_back(e);
      end
  endtask

  // Entered and left at posedge+1.
  task automatic do_start(input int w, input int h, input bit exp_err);
    start = 1'b1;
    cfg_w = CW'(w);
    cfg_h = CW'(h);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err", 72'(cfg_err), 72'(exp_err));
    chk("busy_after_start", 72'(busy), 72'(!exp_err));
    @(posedge clk); #1;
    if (exp_err) chk("cfg_err_pulse", 72'(cfg_err), 72'(0));
  endtask

  task automatic send_pixels(input int npix, input int gapmax, output int stalls);
    int n;
    stalls = 0;
    for (int i = 0; i < npix; i++) begin
      if (gapmax > 0) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
      end
      pix_valid = 1'b1;
      pix_data  = frame_pix[i];
      n = 0;
      @(negedge clk);
      while (!pix_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
        chk("pix_ready_timeout", 72'(n), 72'(0));
        pix_valid = 1'b0;
        return;
      end
      stalls += n;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int gapmax, input bit hold);
    int d0, stalls, n;
    logic [71:0] fw;
    captured = 1'b0;
    d0 = done_cnt;
    do_start(w, h, 1'b0);
    push_frame(w, h);
    if (hold) begin
      start = 1'b1;
      cfg_w = CW'(3);
      cfg_h = CW'(3);
    end
    send_pixels(w*h, gapmax, stalls);
    start = 1'b0;
    if (rdy_mode == 0 && gapmax == 0) chk("pix_ready_stalls", 72'(stalls), 72'(0));
    n = 0;
    @(negedge clk);
    while (!done && n < 5000) begin @(negedge clk); n++; end
    chk("done_seen", 72'(n < 5000), 72'(1));
    @(negedge clk);
    chk("done_pulse", 72'(done), 72'(0));
    chk("done_count", 72'(done_cnt - d0), 72'(1));
    chk("busy_idle", 72'(busy), 72'(0));
    chk("results_left", 72'(exp_q.size()), 72'(0));
    fw = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) fw[(r*3+c)*8 +: 8] = frame_pix[r*w + c];
    chk("first_window", first_win, fw);
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    int w, h;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_cfg_err", 72'(cfg_err), 72'(0));
    chk("rst_pix_ready", 72'(pix_ready), 72'(0));
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_win_data", win_data, 72'(0));
    chk("rst_res_valid", 72'(res_valid), 72'(0));
    chk("rst_res_data", 72'(res_data), 72'(0));
    chk("rst_res_last", 72'(res_last), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp at full throughput, then 5x3 with alternating back-pressure
    fill_seq(16);
    run_frame(4, 4, 0, 1'b0);
    rdy_mode = 1;
    fill_seq(15);
    run_frame(5, 3, 0, 1'b0);
    rdy_mode = 0;

    // Illegal geometry
    do_start(2, 4, 1'b1);
    do_start(4, MH + 1, 1'b1);
    do_start(MW + 1, 4, 1'b1);
    do_start(4, 2, 1'b1);

    // Abort mid-frame, then a fresh 3x3 frame
    fill_seq(16);
    do_start(4, 4, 1'b0);
    send_pixels(7, 0, st);
    st = done_cnt;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", 72'(busy), 72'(0));
    chk("abort_pix_ready", 72'(pix_ready), 72'(0));
    chk("abort_res_valid", 72'(res_valid), 72'(0));
    chk("abort_win_valid", 72'(win_valid), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_done", 72'(done_cnt - st), 72'(0));
    fill_seq(9);
    run_frame(3, 3, 0, 1'b0);

    // start held through a frame, then an immediate second frame
    fill_rand(20);
    run_frame(5, 4, 0, 1'b1);
    fill_rand(12);
    run_frame(4, 3, 0, 1'b0);

    // Randomised frames with max-pool stub, random gaps and back-pressure
    stub_mode = 1;
    rdy_mode  = 2;
    fill_rand(MW*3);
    run_frame(MW, 3, 1, 1'b0);
    fill_rand(3*MH);
    run_frame(3, MH, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(3, 10);
      h = $urandom_range(3, 10);
      fill_rand(w*h);
      run_frame(w, h, 2, (k == 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kp_window_sched.md
# kp_window_sched

Streaming 3x3 window scheduler for the `kernalpooling` datapath. It accepts a raster-scan pixel stream and builds stride-1 3x3 windows using two line buffers. Each complete window is presented to `kernalpooling` on its 72-bit input, and the 8-bit pooled result is registered onto a valid/ready output stream. Frame geometry is configured at run time. A start/busy/done control handshake sequences one frame per start.

## Interface
- `DWIDTH`, 8, pixel and result width.
- `MAX_W`, 64, maximum frame width; sets line-buffer depth.
- `MAX_H`, 64, maximum frame height.
- `CW`, 8, width of `cfg_w`/`cfg_h`; must cover `MAX_W` and `MAX_H`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame start request.
- `cfg_w`  in  CW  frame width, latched on accepted `start`.
- `cfg_h`  in  CW  frame height, latched on accepted `start`.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse after the last result handshake.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected for illegal geometry.
- `pix_valid`  in  1  input pixel valid.
- `pix_ready`  out  1  input pixel ready.
- `pix_data`  in  DWIDTH  input pixel, raster order.
- `win_data`  out  9*DWIDTH  window to `kernalpooling` `b`.
- `win_valid`  out  1  `win_data` holds a complete window.
- `pool_in`  in  DWIDTH  `kernalpooling` `out`; combinational from `win_data`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result ready.
- `res_data`  out  DWIDTH  pooled result.
- `res_last`  out  1  qualifies the final result of the frame.

## Operation
- FSM states: IDLE, LOAD, FLUSH.
- IDLE → LOAD on `start` with 3 ≤ `cfg_w` ≤ `MAX_W` and 3 ≤ `cfg_h` ≤ `MAX_H`. Geometry is latched and the row/col counters are cleared.
- IDLE with `start` and illegal geometry: pulse `cfg_err` the next cycle and stay in IDLE.
- `start` is ignored outside IDLE.
- LOAD: a pixel is accepted on `pix_valid && pix_ready`. `col` increments and wraps to 0 at `cfg_w-1`, which increments `row`.
- LOAD → FLUSH on acceptance of pixel (`cfg_h-1`, `cfg_w-1`).
- FLUSH → IDLE when the pipeline is empty and the last result has been handshaken. `done` pulses in that same transition cycle.
- Line buffers: two `MAX_W`-deep `DWIDTH` rows, indexed by `col`, written only on accept. Contents from previous rows or frames are never cleared; correctness relies on window gating.
- Window registers: a 3x3 array shifted left by one column on each accept.
  - Column 2 is loaded with {linebuf1[col], linebuf0[col], `pix_data`}, ordered rows 0, 1, 2.
  - Row 0 is the oldest row (y-2); column 0 is the oldest column (x-2).
- Packing: element (r,c) sits at `win_data[(r*3+c)*DWIDTH +: DWIDTH]`. Bits [71:64] therefore carry the newest pixel.
- A window is complete when the accepted pixel has `row ≥ 2 && col ≥ 2`. No windows straddle row boundaries.
- Result count per frame is (`cfg_w`-2)*(`cfg_h`-2). `res_last` is set on the result from pixel (`cfg_h-1`, `cfg_w-1`).

## Timing
- Pipeline: S1 = window register plus `win_valid`; S2 = result register plus `res_valid`.
- `s2_take = !res_valid || res_ready`.
- `s1_take = !win_valid || s2_take`.
- `pix_ready = (state==LOAD) && s1_take`.
- Pixel accepted in cycle N → `win_valid` in N+1 (if the window is complete) → `res_data` captured from `pool_in` at the end of N+1 when `s2_take` → `res_valid` in N+2. Minimum latency is 2 cycles.
- Full throughput is one pixel per cycle with `res_ready` held high.
- `res_valid`/`res_data`/`res_last` hold stable while `res_valid && !res_ready`.
- `win_valid` clears when S1 drains without a new complete window.
- `pool_in` is sampled only when `win_valid && s2_take`.
- Reset values: all outputs 0, state IDLE, counters 0, window registers 0.
- Reset mid-frame aborts the frame immediately: no `done`, and partial results are dropped.

## Test plan
- Stub `pool_in = win_data[71:64]`. 4x4 frame, pixels 0..15, `res_ready`=1 → results 10, 11, 14, 15; `res_last` only on 15; `done` pulses once; `pix_ready` is never low in LOAD.
- Same stimulus, check `win_data` for the first window → elements (r,c) = 0,1,2 / 4,5,6 / 8,9,10.
- 5x3 frame with `res_ready` toggling every other cycle → results 12, 13, 14 with no loss or duplication; `res_data` stable while stalled.
- `start` with `cfg_w`=2, then `cfg_h`=`MAX_H`+1 → `cfg_err` pulses each time; `busy` stays 0.
- Assert `rst_n`=0 after 7 pixels of a 4x4 frame, then run a fresh 3x3 frame of 0..8 → exactly one result, 8; no stale output.
- Back-to-back frames: `start` held during the frame → ignored; a second `start` after `done` processes the new frame correctly.
